// File: rtl/sw_debounce_sync.sv
// Two-flop synchroniser plus per-bit debounce for the board switch bus, with registered
// rise/fall/changed event pulses. Define SW_TOGGLE_EN to add latched per-bit toggle flags.
module sw_debounce_sync #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] sw_raw_i,
    output logic [WIDTH-1:0] sw_stable_o,
    output logic [WIDTH-1:0] sw_rise_o,
    output logic [WIDTH-1:0] sw_fall_o,
    output logic             sw_changed_o
`ifdef SW_TOGGLE_EN
    ,
    output logic [WIDTH-1:0] sw_toggle_o
`endif
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            // Counter only advances while the synchronised bit disagrees with the stable bit.
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                    rise_d[i]   = sync2_q[i];
                    fall_d[i]   = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sw_raw_i;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_stable_o  = stable_q;
    assign sw_rise_o    = rise_q;
    assign sw_fall_o    = fall_q;
    assign sw_changed_o = changed_q;

`ifdef SW_TOGGLE_EN
    logic [WIDTH-1:0] toggle_q, toggle_d;

    // Flip off the registered rise pulse, so the flag settles one cycle after the pulse.
    always_comb begin
        toggle_d = toggle_q ^ rise_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            toggle_q <= '0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign sw_toggle_o = toggle_q;
`endif

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed bench for sw_debounce_sync with DB_CYCLES=4: reset, clean step, bounce, glitch,
// simultaneous bits, reset mid-count, and (with SW_TOGGLE_EN) toggle flags.
module tb_sw_debounce_sync;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DB    = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;
`ifdef SW_TOGGLE_EN
    logic [WIDTH-1:0] sw_toggle;
`endif

    int n_vec = 0;
    int n_err = 0;

    sw_debounce_sync #(
        .WIDTH    (WIDTH),
        .DB_CYCLES(DB)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sw_raw_i    (sw_raw),
        .sw_stable_o (sw_stable),
        .sw_rise_o   (sw_rise),
        .sw_fall_o   (sw_fall),
        .sw_changed_o(sw_changed)
`ifdef SW_TOGGLE_EN
        ,
        .sw_toggle_o (sw_toggle)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic [WIDTH-1:0] v);
        sw_raw = v;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        sw_raw = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({sw_stable, sw_rise, sw_fall, sw_changed} !== '0) begin
                n_err++;
                $display("FAIL reset_hold cyc%0d: stable=%h rise=%h fall=%h chg=%b want all 0",
                         i, sw_stable, sw_rise, sw_fall, sw_changed);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_vec++;
            if (e < 6 && {sw_stable, sw_rise, sw_fall, sw_changed} !== '0) begin
                n_err++;
                $display("FAIL reset_release e%0d: stable=%h rise=%h chg=%b want 0",
                         e, sw_stable, sw_rise, sw_changed);
            end else if (e == 6 && (sw_stable !== 16'hFFFF || sw_rise !== 16'hFFFF
                                    || sw_changed !== 1'b1)) begin
                n_err++;
                $display("FAIL reset_accept: stable=%h rise=%h chg=%b want ffff ffff 1",
                         sw_stable, sw_rise, sw_changed);
            end else if (e == 7 && (sw_stable !== 16'hFFFF || sw_rise !== '0
                                    || sw_changed !== 1'b0)) begin
                n_err++;
                $display("FAIL reset_after: stable=%h rise=%h chg=%b want ffff 0000 0",
                         sw_stable, sw_rise, sw_changed);
            end
        end
        settle('0);
        n_vec++;
        if (sw_stable !== '0) begin
            n_err++;
            $display("FAIL reset_fall_back: stable=%h want 0000", sw_stable);
        end
    endtask

    task automatic test_clean_step();
        sw_raw = 16'h0020;
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_vec++;
            if (e < 6 && (sw_stable !== '0 || sw_changed !== 1'b0)) begin
                n_err++;
                $display("FAIL step_wait e%0d: stable=%h chg=%b want 0000 0",
                         e, sw_stable, sw_changed);
            end else if (e == 6 && (sw_stable !== 16'h0020 || sw_rise !== 16'h0020
                                    || sw_fall !== '0 || sw_changed !== 1'b1)) begin
                n_err++;
                $display("FAIL step_accept: stable=%h rise=%h fall=%h chg=%b want 0020 0020 0 1",
                         sw_stable, sw_rise, sw_fall, sw_changed);
            end else if (e == 7 && (sw_stable !== 16'h0020 || sw_rise !== '0
                                    || sw_changed !== 1'b0)) begin
                n_err++;
                $display("FAIL step_pulse_end: stable=%h rise=%h chg=%b want 0020 0 0",
                         sw_stable, sw_rise, sw_changed);
            end
        end
        settle('0);
    endtask

    task automatic test_bounce();
        int rises = 0;
        int bad   = 0;
        for (int c = 0; c < 20; c++) begin
            sw_raw = ((c / 2) % 2 == 0) ? 16'h0001 : 16'h0000;
            tick();
            rises += int'(sw_rise[0]);
            if (sw_stable[0] !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bounce_stable: %0d cycles with stable[0]=1, want 0", bad);
        end
        sw_raw = 16'h0001;
        for (int e = 1; e <= 12; e++) begin
            tick();
            rises += int'(sw_rise[0]);
            if (e == 5 || e == 6) begin
                n_vec++;
                if (sw_stable[0] !== (e == 6)) begin
                    n_err++;
                    $display("FAIL bounce_latency e%0d: stable[0]=%b want %0d",
                             e, sw_stable[0], e == 6);
                end
            end
        end
        n_vec++;
        if (rises != 1) begin
            n_err++;
            $display("FAIL bounce_rise_count: got %0d pulses want 1", rises);
        end
        settle('0);
    endtask

    task automatic test_glitch_simultaneous();
        int chg = 0;
        int bad = 0;
        sw_raw = 16'h0008;
        tick();
        sw_raw = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (sw_stable !== '0 || sw_changed !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL glitch: %0d cycles with output activity, want 0", bad);
        end
        sw_raw = 16'hA5A5;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chg += int'(sw_changed);
            if (e == 6) begin
                n_vec++;
                if (sw_stable !== 16'hA5A5 || sw_rise !== 16'hA5A5 || sw_fall !== '0) begin
                    n_err++;
                    $display("FAIL simul_rise: stable=%h rise=%h fall=%h want a5a5 a5a5 0",
                             sw_stable, sw_rise, sw_fall);
                end
            end
        end
        n_vec++;
        if (chg != 1) begin
            n_err++;
            $display("FAIL simul_changed_count: got %0d want 1", chg);
        end
        sw_raw = 16'h0000;
        for (int e = 1; e <= 6; e++) tick();
        n_vec++;
        if (sw_stable !== '0 || sw_fall !== 16'hA5A5 || sw_rise !== '0
            || sw_changed !== 1'b1) begin
            n_err++;
            $display("FAIL simul_fall: stable=%h fall=%h rise=%h chg=%b want 0 a5a5 0 1",
                     sw_stable, sw_fall, sw_rise, sw_changed);
        end
        settle('0);
    endtask

    task automatic test_reset_mid_count();
        sw_raw = 16'h0080;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (sw_stable !== '0 || sw_rise !== '0 || sw_changed !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_hold: stable=%h rise=%h chg=%b want 0 0 0",
                     sw_stable, sw_rise, sw_changed);
        end
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 5 || e == 6) begin
                n_vec++;
                if (sw_stable !== ((e == 6) ? 16'h0080 : 16'h0000)
                    || sw_rise !== ((e == 6) ? 16'h0080 : 16'h0000)) begin
                    n_err++;
                    $display("FAIL midrst_restart e%0d: stable=%h rise=%h", e, sw_stable, sw_rise);
                end
            end
        end
        settle('0);
    endtask

`ifdef SW_TOGGLE_EN
    task automatic test_toggle();
        logic [WIDTH-1:0] exp_after_press [2];
        exp_after_press[0] = 16'h8000;
        exp_after_press[1] = 16'h0000;
        n_vec++;
        if (sw_toggle !== '0) begin
            n_err++;
            $display("FAIL toggle_init: got %h want 0000", sw_toggle);
        end
        for (int p = 0; p < 2; p++) begin
            settle(16'h8000);
            n_vec++;
            if (sw_toggle !== exp_after_press[p]) begin
                n_err++;
                $display("FAIL toggle_press%0d: got %h want %h", p, sw_toggle, exp_after_press[p]);
            end
            settle(16'h0000);
            n_vec++;
            if (sw_toggle !== exp_after_press[p]) begin
                n_err++;
                $display("FAIL toggle_release%0d: got %h want %h",
                         p, sw_toggle, exp_after_press[p]);
            end
        end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        sw_raw = '0;
        test_reset();
        test_clean_step();
        test_bounce();
        test_glitch_simultaneous();
        test_reset_mid_count();
`ifdef SW_TOGGLE_EN
        test_toggle();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
